// File: rtl/uart_rx_flow.sv
// UART receiver: deframes serial characters from the line into a FIFO.
// Latency: pushed byte visible on io_data/io_valid 1 cycle after the stop-bit sample.
// Backpressure: io_rts asks the peer to pause when the FIFO is filling up; bytes that still arrive while the FIFO is full are dropped (io_overrun).
//
// Ports:
//   io_clock, io_reset_n        clock / async active-low reset
//   io_rxd                      serial line in (idle high, asynchronous)
//   io_rts                      active-low request-to-send (1 = peer must pause)
//   io_data/io_valid/io_ready   receive stream (FIFO head)
//   io_count                    FIFO fill level
//   io_frameError/io_overrun/io_parityError   one-cycle error pulses
// Optional: define UART_RX_PARITY_EN to expect a parity bit after the data bits.
module uart_rx_flow #(
    parameter int CLK_FREQ_HZ   = 100000000,
    parameter int BAUD          = 115200,
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int RTS_THRESHOLD = 12,
    parameter int PARITY_ODD    = 0
) (
    input  logic                          io_clock,
    input  logic                          io_reset_n,
    input  logic                          io_rxd,
    output logic                          io_rts,
    output logic [DATA_BITS-1:0]          io_data,
    output logic                          io_valid,
    input  logic                          io_ready,
    output logic [$clog2(FIFO_DEPTH):0]   io_count,
    output logic                          io_frameError,
    output logic                          io_overrun,
    output logic                          io_parityError
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CW  = $clog2(CLKS_PER_BIT + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int NW  = AW + 1;
    localparam int BIW = $clog2(DATA_BITS);

    localparam logic [CW-1:0]  HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [BIW-1:0] LAST_BIT    = BIW'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    // ------------------------------------------------------------------
    // Input synchroniser; flops preset to the idle (mark) level so reset
    // release never looks like a start bit.
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rxs;

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= io_rxd;
            rxs     <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Deframing FSM. cnt counts down to the next sample point; START waits
    // half a bit so every later sample lands mid-bit.
    // ------------------------------------------------------------------
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [BIW-1:0]       bit_idx;
    logic [DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state <= ST_START;
                        cnt   <= HALF_RELOAD;
                    end
                end
                ST_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rxs) begin
                        state   <= ST_DATA;
                        cnt     <= FULL_RELOAD;
                        bit_idx <= '0;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // LSB arrives first, so shift in from the top.
                        shift <= {rxs, shift[DATA_BITS-1:1]};
                        cnt   <= FULL_RELOAD;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        par_bit <= rxs;
                        state   <= ST_STOP;
                        cnt     <= FULL_RELOAD;
                    end
                end
`endif
                ST_STOP: begin
                    // Leave mid stop bit so a back-to-back start edge is seen.
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stop-bit decision
    // ------------------------------------------------------------------
    logic stop_hit;
    logic frame_bad;
    logic push_req;

    assign stop_hit  = (state == ST_STOP) && (cnt == '0);
    assign frame_bad = stop_hit && !rxs;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    // Data XOR parity bit is 0 for even parity, 1 for odd.
    assign par_bad  = stop_hit && ((^shift ^ par_bit) != (PARITY_ODD != 0));
    assign push_req = stop_hit && rxs && !par_bad;
`else
    assign push_req = stop_hit && rxs;
`endif

    // ------------------------------------------------------------------
    // Receive FIFO. A push into a full FIFO still succeeds when the head
    // is popped in the same cycle: the write lands in the freed slot.
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [NW-1:0]        count;
    logic [NW-1:0]        count_next;
    logic                 pop;
    logic                 has_room;
    logic                 push;
    logic                 rts_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    assign pop      = io_valid && io_ready;
    assign has_room = (count < NW'(FIFO_DEPTH)) || pop;
    assign push     = push_req && has_room;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rts_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count       <= count_next;
            rts_q       <= (count_next >= NW'(RTS_THRESHOLD));
            frame_err_q <= frame_bad;
            overrun_q   <= push_req && !has_room;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= par_bad;
        end
    end

    assign io_parityError = parity_err_q;
`else
    assign io_parityError = 1'b0;
`endif

    assign io_data       = mem[rd_ptr];
    assign io_valid      = (count != '0);
    assign io_count      = count;
    assign io_rts        = rts_q;
    assign io_frameError = frame_err_q;
    assign io_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_flow.sv
// Testbench for uart_rx_flow: serial frames driven bit by bit, received
// bytes and error pulses checked against a queue-based expectation model.
module tb_uart_rx_flow;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int THR   = 12;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;   // start + 8 data + parity, stop sampled mid-bit
`else
    localparam int NBITS = 9;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b0;
    logic       rts;
    logic [7:0] data;
    logic       valid;
    logic [4:0] count;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    uart_rx_flow #(
        .CLK_FREQ_HZ  (1600000),
        .BAUD         (100000),
        .DATA_BITS    (8),
        .FIFO_DEPTH   (DEPTH),
        .RTS_THRESHOLD(THR),
        .PARITY_ODD   (0)
    ) dut (
        .io_clock      (clk),
        .io_reset_n    (rst_n),
        .io_rxd        (rxd),
        .io_rts        (rts),
        .io_data       (data),
        .io_valid      (valid),
        .io_ready      (ready),
        .io_count      (count),
        .io_frameError (frame_err),
        .io_overrun    (overrun),
        .io_parityError(parity_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int valid_rise_cyc = -1;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, pop_cnt = 0;
    int exp_fe = 0, exp_ov = 0, exp_pe = 0;
    logic [7:0] exp_q[$];
    bit valid_d = 1'b0;
    bit rnd_ready = 1'b0;
`ifdef UART_RX_PARITY_EN
    bit bad_par = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Consumer side of the model: every handshake must deliver the oldest
    // expected byte; error pulses are tallied once per high cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && !valid_d) valid_rise_cyc = cyc;
            if (frame_err)  fe_cnt++;
            if (overrun)    ov_cnt++;
            if (parity_err) pe_cnt++;
            if (valid && ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) check_eq("pop_expected", 0, 1);
                else                   check_eq("pop_data", data, exp_q.pop_front());
            end
        end
        valid_d = valid;
    end

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1 ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic drive_bit(input logic b);
        @(negedge clk);
        rxd = b;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        start_cyc = cyc;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ bad_par);
`endif
        drive_bit(stop_bit);
        rxd = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((valid || exp_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, (n < 2000), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int         p0;
        logic       stop_ok;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", valid, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_data", data, 0);
        check_eq("rst_rts", rts, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_ovr", overrun, 0);
        check_eq("rst_perr", parity_err, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // ---------------- single 0x55, latency ----------------
        ready = 1'b1;
        valid_rise_cyc = -1;
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check_eq("t1_latency_ok",
                 (valid_rise_cyc >= start_cyc + CPB * NBITS) &&
                 (valid_rise_cyc <= start_cyc + CPB * NBITS + CPB / 2 + 4), 1);
        check_eq("t1_pops", pop_cnt, 1);
        check_eq("t1_ferr", fe_cnt, exp_fe);
        check_eq("t1_perr", pe_cnt, exp_pe);

        // ---------------- short low glitch ----------------
        p0 = pop_cnt;
        @(negedge clk) rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_eq("t2_no_pop", pop_cnt, p0);
        check_eq("t2_ferr", fe_cnt, exp_fe);
        exp_q.push_back(8'hA3);
        send(8'hA3, 1'b1);
        wait_drain("t2_drain");
        check_eq("t2_a3_pop", pop_cnt, p0 + 1);

        // ---------------- framing error ----------------
        ready = 1'b0;
        exp_fe++;
        send(8'hA3, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check_eq("t3_ferr", fe_cnt, exp_fe);
        check_eq("t3_count", count, 0);
        check_eq("t3_valid", valid, 0);

        // ---------------- fill, RTS, overrun ----------------
        for (int i = 0; i < 17; i++) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
            else                      exp_ov++;
            send(8'(i), 1'b1);
            check_eq("t4_count", count, exp_q.size());
            check_eq("t4_rts", rts, (exp_q.size() >= THR));
        end
        repeat (4) @(negedge clk);
        check_eq("t4_ovr", ov_cnt, exp_ov);
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk) #1 ready = 1'b1;
            @(posedge clk) #1 ready = 1'b0;
            @(negedge clk);
            check_eq("t4_drain_count", count, exp_q.size());
            check_eq("t4_drain_rts", rts, (exp_q.size() >= THR));
        end

        // ---------------- randomized stream ----------------
        rnd_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            d = 8'($urandom);
            stop_ok = ($urandom_range(0, 7) != 0);
            if (stop_ok) exp_q.push_back(d);
            else         exp_fe++;
            send(d, stop_ok);
            // After a bad stop bit the line needs a bit time to resynchronise.
            repeat ($urandom_range(0, 2 * CPB) + (stop_ok ? 0 : CPB)) @(negedge clk);
        end
        @(negedge clk);
        rnd_ready = 1'b0;
        ready = 1'b1;
        wait_drain("t5_drain");
        check_eq("t5_model_empty", exp_q.size(), 0);
        check_eq("t5_count", count, 0);
        check_eq("t5_ferr", fe_cnt, exp_fe);
        check_eq("t5_ovr", ov_cnt, exp_ov);

        // ---------------- parity ----------------
`ifdef UART_RX_PARITY_EN
        p0 = pop_cnt;
        bad_par = 1'b0;
        exp_q.push_back(8'h07);
        send(8'h07, 1'b1);
        bad_par = 1'b1;
        exp_pe++;
        send(8'h07, 1'b1);
        bad_par = 1'b0;
        wait_drain("t6_drain");
        repeat (2 * CPB) @(negedge clk);
        check_eq("t6_pops", pop_cnt, p0 + 1);
`endif
        check_eq("t6_perr", pe_cnt, exp_pe);

        // ---------------- reset mid-frame ----------------
        ready = 1'b0;
        for (int i = 0; i < THR; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            send(d, 1'b1);
        end
        check_eq("t7_pre_rts", rts, 1);
        check_eq("t7_pre_count", count, THR);
        d = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        @(negedge clk) rxd = d[3];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t7_rst_valid", valid, 0);
        check_eq("t7_rst_count", count, 0);
        check_eq("t7_rst_rts", rts, 0);
        exp_q.delete();
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_eq("t7_idle_valid", valid, 0);
        p0 = pop_cnt;
        ready = 1'b1;
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1);
        wait_drain("t7_drain");
        check_eq("t7_pop", pop_cnt, p0 + 1);
        check_eq("t7_ferr", fe_cnt, exp_fe);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
